// File: rtl/htif_host_link.sv
// Host-side initiator for the 4-bit HTIF nibble link.
// Takes one command at a time and sends it to the target as a nibble packet.
// It then collects the target's nibble response, checks the ack header, and
// holds the result on the response port until the consumer accepts it.
module htif_host_link #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic [2:0]   req_cmd,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_data,
    output logic         link_out_val,
    output logic [3:0]   link_out_bits,
    input  logic         link_out_rdy,
    input  logic         link_in_val,
    input  logic [3:0]   link_in_bits,
    output logic         link_in_rdy,
    output logic         resp_val,
    input  logic         resp_rdy,
    output logic [127:0] resp_data,
    output logic [1:0]   resp_status
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PKT_W = 168;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               bad_q, bad_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic [127:0]       rdata_q, rdata_d;

    logic               req_rdy_q, req_rdy_d;
    logic               link_out_val_q, link_out_val_d;
    logic [3:0]         link_out_bits_q, link_out_bits_d;
    logic               link_in_rdy_q, link_in_rdy_d;
    logic               resp_val_q, resp_val_d;
    logic [127:0]       resp_data_q, resp_data_d;
    logic [1:0]         resp_status_q, resp_status_d;

    logic [CNT_W-1:0]   idx_inc;
    logic [CNT_W-1:0]   idx_dec2;

    // Index of the last nibble the host sends for a command.
    function automatic logic [CNT_W-1:0] out_last(input logic [2:0] cmd);
        case (cmd)
            3'd1:    return CNT_W'(41);
            3'd3:    return CNT_W'(17);
            3'd5:    return CNT_W'(1);
            default: return CNT_W'(9);
        endcase
    endfunction

    // Index of the last nibble the target returns for a command.
    function automatic logic [CNT_W-1:0] in_last(input logic [2:0] cmd);
        case (cmd)
            3'd0:    return CNT_W'(33);
            3'd2:    return CNT_W'(9);
            default: return CNT_W'(1);
        endcase
    endfunction

    assign idx_inc  = idx_q + CNT_W'(1);
    assign idx_dec2 = idx_q - CNT_W'(2);

    assign req_rdy       = req_rdy_q;
    assign link_out_val  = link_out_val_q;
    assign link_out_bits = link_out_bits_q;
    assign link_in_rdy   = link_in_rdy_q;
    assign resp_val      = resp_val_q;
    assign resp_data     = resp_data_q;
    assign resp_status   = resp_status_q;

    // Next-state and registered-output computation for the link FSM.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        tmo_d           = tmo_q;
        bad_d           = bad_q;
        cmd_d           = cmd_q;
        pkt_d           = pkt_q;
        rdata_d         = rdata_q;
        link_out_val_d  = 1'b0;
        link_out_bits_d = 4'h0;
        resp_data_d     = resp_data_q;
        resp_status_d   = resp_status_q;

        case (state_q)
            IDLE: begin
                if (req_val && req_rdy_q) begin
                    cmd_d       = req_cmd;
                    // Whole packet laid out low nibble first: cmd byte, addr, data.
                    pkt_d       = {req_data, req_addr, 5'b0, req_cmd};
                    rdata_d     = '0;
                    bad_d       = 1'b0;
                    idx_d       = '0;
                    tmo_d       = '0;
                    resp_data_d = '0;
                    if (req_cmd > 3'd5) begin
                        state_d       = RESP;
                        resp_status_d = 2'd3;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (!link_out_val_q) begin
                    // Hold off the first nibble until the target is ready.
                    if (link_out_rdy) begin
                        link_out_val_d  = 1'b1;
                        link_out_bits_d = pkt_q[3:0];
                    end
                end else if (!link_out_rdy) begin
                    // The target faults on a gap, so a stall mid-packet is fatal.
                    state_d       = RESP;
                    resp_status_d = 2'd3;
                    resp_data_d   = '0;
                end else if (idx_q == out_last(cmd_q)) begin
                    state_d = RECV;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else begin
                    idx_d           = idx_inc;
                    link_out_val_d  = 1'b1;
                    link_out_bits_d = pkt_q[{idx_inc, 2'b00} +: 4];
                end
            end
            RECV: begin
                if (link_in_val && link_in_rdy_q) begin
                    tmo_d = '0;
                    if ((idx_q == CNT_W'(0)) && (link_in_bits != 4'h6)) begin
                        bad_d = 1'b1;
                    end
                    if ((idx_q == CNT_W'(1)) && (link_in_bits != 4'h0)) begin
                        bad_d = 1'b1;
                    end
                    if (idx_q >= CNT_W'(2)) begin
                        rdata_d[{idx_dec2, 2'b00} +: 4] = link_in_bits;
                    end
                    if (idx_q == in_last(cmd_q)) begin
                        state_d       = RESP;
                        resp_status_d = bad_d ? 2'd1 : 2'd0;
                        resp_data_d   = rdata_d;
                    end else begin
                        idx_d = idx_inc;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = RESP;
                    resp_status_d = 2'd2;
                    resp_data_d   = '0;
                    tmo_d         = TMO_W'(TIMEOUT_CYCLES);
                end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    state_d       = IDLE;
                    resp_data_d   = '0;
                    resp_status_d = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_rdy_d     = (state_d == IDLE);
        link_in_rdy_d = (state_d == RECV);
        resp_val_d    = (state_d == RESP);
    end

    // Control state and all port-visible outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            tmo_q           <= '0;
            bad_q           <= 1'b0;
            cmd_q           <= 3'd0;
            req_rdy_q       <= 1'b0;
            link_out_val_q  <= 1'b0;
            link_out_bits_q <= 4'h0;
            link_in_rdy_q   <= 1'b0;
            resp_val_q      <= 1'b0;
            resp_data_q     <= '0;
            resp_status_q   <= 2'd0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            tmo_q           <= tmo_d;
            bad_q           <= bad_d;
            cmd_q           <= cmd_d;
            req_rdy_q       <= req_rdy_d;
            link_out_val_q  <= link_out_val_d;
            link_out_bits_q <= link_out_bits_d;
            link_in_rdy_q   <= link_in_rdy_d;
            resp_val_q      <= resp_val_d;
            resp_data_q     <= resp_data_d;
            resp_status_q   <= resp_status_d;
        end
    end

    // Packet and response payload storage; always rewritten before use.
    always_ff @(posedge clk) begin
        pkt_q   <= pkt_d;
        rdata_q <= rdata_d;
    end

endmodule

// File: doc/htif_host_link.md
Name: htif_host_link

Overview:
- Host-side initiator for the 4-bit HTIF nibble link. It is the opposite end of the on-chip HTIF target.
- Accepts one command at a time on a valid/ready request port (read/write mem, read/write CR, start, stop).
- Serialises the command into a contiguous nibble packet, collects the target's nibble response, checks the ack header, and returns the data on a held response port.
- Sits in the FPGA/test-harness bridge, driving the chip's in_* pins and receiving its out_* pins.

Parameters:
TIMEOUT_CYCLES, 1024, max idle cycles waiting for any response nibble before abort
CNT_W, 6, nibble counter width (must hold 42)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_val  in  1  command request valid
req_rdy  out  1  block idle, accepts request
req_cmd  in  3  0 rdmem, 1 wrmem, 2 rdcr, 3 wrcr, 4 start, 5 stop, 6/7 illegal
req_addr  in  32  address / CR selector (bits 17:16 pick core)
req_data  in  128  write data; wrcr uses [31:0]
link_out_val  out  1  nibble valid to target (target in_val)
link_out_bits  out  4  nibble to target
link_out_rdy  in  1  target in_rdy
link_in_val  in  1  target out_val
link_in_bits  in  4  target out_bits
link_in_rdy  out  1  to target out_rdy
resp_val  out  1  response valid, held until resp_rdy
resp_rdy  in  1  response accepted
resp_data  out  128  rdmem: full line; rdcr: [31:0], upper zero; others zero
resp_status  out  2  0 ok, 1 bad header, 2 timeout, 3 illegal cmd / link drop

Behaviour:
- Reset (rst=1, synchronous): state IDLE, counters 0; req_rdy=0, link_out_val=0, link_out_bits=0, link_in_rdy=0, resp_val=0, resp_data=0, resp_status=0. A reset mid-packet abandons the transfer immediately; no further nibbles are driven.
- Packet format, host to target, nibble index n:
  - n0,n1 = cmd byte {0, cmd}, low nibble first.
  - n2..n9 = addr, n2 = addr[3:0].
  - n10..n17 = wrcr data [31:0].
  - n10..n41 = wrmem data [127:0], n10 = data[3:0].
  - Lengths: rdmem 10, wrmem 42, rdcr 10, wrcr 18, start 10, stop 2.
- Response format, target to host:
  - n0,n1 must be 0x6,0x0 (ack 0x06).
  - rdmem data in n2..n33 (n2 = bits 3:0); rdcr data in n2..n9.
  - Lengths: rdmem 34, rdcr 10, all others 2.
- States: IDLE, SEND, RECV, RESP.
- IDLE:
  - req_rdy=1.
  - On req_val&&req_rdy: latch cmd/addr/data.
  - Illegal cmd: go to RESP with status 3; no link traffic.
  - Otherwise go to SEND with idx=0.
- SEND:
  - link_out_bits = nibble[idx].
  - The first nibble waits for link_out_rdy=1 (link_out_val=0 until then).
  - From the first transfer onward, link_out_val=1 every cycle and idx increments every cycle. No bubbles are allowed: the target faults on a gap.
  - If link_out_rdy=0 after the first nibble: drop link_out_val, go to RESP with status 3.
  - After the last nibble (idx == len-1): link_out_val=0 next cycle, go to RECV with idx=0 and timeout counter cleared.
- RECV:
  - link_in_rdy=1.
  - On link_in_val&&link_in_rdy: store the nibble, idx++, clear the timeout counter.
  - A mismatching n0/n1 sets a sticky bad-header flag; the full expected length is still consumed.
  - After the last expected nibble: go to RESP with status 1 if the flag is set, else 0.
  - Each cycle without a transfer increments the timeout counter. At TIMEOUT_CYCLES: link_in_rdy=0, go to RESP with status 2, resp_data=0.
- RESP:
  - resp_val=1; resp_data and resp_status are stable.
  - On resp_rdy: go to IDLE (resp_val=0 next cycle).
  - req_rdy is 0 in all states except IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency: minimum request to resp_val = 1 + len_out + 1 (target processing) + len_in + 1 cycles.
- Arithmetic: idx is CNT_W bits; comparisons use len-1 with no wrap; the timeout counter saturates.
- Simultaneous events:
  - link_in_val and the timeout terminal count in the same cycle: the transfer wins and the counter clears.
  - req_val during non-IDLE is ignored.

Test Plan:
- wrcr addr=0x0001_0000 data=0xDEADBEEF:
  - link nibbles 3,0,0,0,0,0,1,0,0,0,F,E,E,B,D,A,E,D, contiguous.
  - Target returns 6,0; resp_status=0, resp_data=0.
- rdmem addr=0x40:
  - 10 nibbles sent.
  - Model returns 6,0 then 32 nibbles of 0x0123...CDEF line.
  - resp_data equals the line, status 0, after at least 45 cycles.
- rdcr with model returning header 7,0:
  - All 10 nibbles consumed.
  - resp_status=1.
- stop with model silent:
  - resp_status=2 exactly TIMEOUT_CYCLES cycles after the last sent nibble.
  - link_in_rdy drops.
- wrmem with link_out_rdy pulled low at nibble 20:
  - link_out_val drops.
  - resp_status=3.
  - Next request (cmd 6) returns status 3 with zero link activity.
- Assert rst during wrmem SEND at nibble 15:
  - All outputs are 0 next cycle.
  - req_rdy=1 the cycle after rst deasserts.
